// File: rtl/tlul_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tlul_pkg
// Purpose  : Minimal TileLink Uncached Lightweight (TL-UL) type definitions
//            shared by the host bridge and anything that connects to it.
// Revision : 1.0 - initial release
// ============================================================================
package tlul_pkg;

    localparam int TL_AW  = 32;  // address width
    localparam int TL_DW  = 32;  // data width
    localparam int TL_AIW = 8;   // A-channel source-ID width
    localparam int TL_DBW = 4;   // byte-mask width
    localparam int TL_SZW = 2;   // size field width

    // A-channel opcodes
    localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] GET              = 3'h4;

    // D-channel opcodes
    localparam logic [2:0] ACCESS_ACK       = 3'h0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;  // 4'h9 marks a data (non-instruction) access
    } tl_a_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: 5'h0, instr_type: 4'h9};

    // Host to device: A channel plus D-channel ready
    typedef struct packed {
        logic                a_valid;
        logic [2:0]          a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        tl_a_user_t          a_user;
        logic                d_ready;
    } tl_h2d_t;

    // Device to host: D channel plus A-channel ready
    typedef struct packed {
        logic                d_valid;
        logic [2:0]          d_opcode;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// ============================================================================
// Module   : tlul_host_bridge
// Purpose  : Converts a core-side req/gnt/rvalid port into TL-UL A-channel
//            requests, collects D-channel responses into per-transaction
//            slots and returns them to the core strictly in issue order.
//            Up to MaxOutstanding transactions may be in flight.
// Ports    : clk_i, rst_ni        - clock, asynchronous active-low reset
//            req_i / gnt_o        - core request valid / accepted this cycle
//            we_i, addr_i,
//            wdata_i, be_i        - request payload (held until gnt_o)
//            rvalid_o             - one-cycle response pulse per transaction
//            rdata_o, err_o       - response data (0 for writes) and error
//            spurious_o           - sticky flag for unmatched D responses
//            tl_o / tl_i          - TL-UL host/device channel bundles
// Revision : 1.0 - initial release
// ============================================================================
module tlul_host_bridge #(
    parameter int MaxOutstanding = 2,
    parameter int SrcW           = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           be_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 spurious_o,
    output tlul_pkg::tl_h2d_t    tl_o,
    input  tlul_pkg::tl_d2h_t    tl_i
);

    import tlul_pkg::*;

    localparam int                 NUM_SLOTS = 2 ** SrcW;
    localparam int                 CNT_W     = $clog2(MaxOutstanding + 1);
    localparam logic [SrcW-1:0]    LAST_PTR  = SrcW'(MaxOutstanding - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MaxOutstanding);
    // One bit wider than d_source so MaxOutstanding == 2**TL_AIW still fits
    localparam logic [TL_AIW:0]    SRC_LIMIT = (TL_AIW + 1)'(MaxOutstanding);

    // ------------------------------------------------------------------
    // Pointer / counter state
    // ------------------------------------------------------------------
    logic [SrcW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [SrcW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             spurious_q, spurious_d;

    // Slot views, indexed by a full SrcW-bit pointer. Entries at or above
    // MaxOutstanding are tied off and never selected.
    logic [NUM_SLOTS-1:0] w_busy;
    logic [NUM_SLOTS-1:0] w_done;
    logic [NUM_SLOTS-1:0] w_is_read;
    logic [NUM_SLOTS-1:0] w_err;
    logic [31:0]          w_slot_data [NUM_SLOTS];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic            w_a_valid;
    logic            w_grant;
    logic            w_retire;
    logic [SrcW-1:0] w_d_idx;
    logic            w_d_in_range;
    logic            w_d_match;
    logic            w_d_err;
    logic [31:0]     w_d_data;

    assign w_a_valid    = req_i && (count_q < MAX_CNT);
    assign w_grant      = w_a_valid && tl_i.a_ready;
    assign w_retire     = w_done[rd_ptr_q];

    assign w_d_idx      = tl_i.d_source[SrcW-1:0];
    assign w_d_in_range = ({1'b0, tl_i.d_source} < SRC_LIMIT);
    // A slot already marked done (including the one retiring this cycle)
    // cannot accept a second response; that response counts as unmatched.
    assign w_d_match    = tl_i.d_valid && w_d_in_range
                          && w_busy[w_d_idx] && !w_done[w_d_idx];

    // Reads expect AccessAckData, writes expect AccessAck; any other
    // opcode is reported as an error alongside d_error.
    assign w_d_err      = tl_i.d_error |
                          (w_is_read[w_d_idx] ? (tl_i.d_opcode != ACCESS_ACK_DATA)
                                              : (tl_i.d_opcode != ACCESS_ACK));
    assign w_d_data     = w_is_read[w_d_idx] ? tl_i.d_data : 32'h0;

    // ------------------------------------------------------------------
    // Per-slot tracking registers
    // ------------------------------------------------------------------
    for (genvar s = 0; s < MaxOutstanding; s++) begin : g_slot
        logic        busy_q,    busy_d;
        logic        done_q,    done_d;
        logic        is_read_q, is_read_d;
        logic        err_q,     err_d;
        logic [31:0] data_q,    data_d;
        logic        w_alloc;
        logic        w_fill;
        logic        w_free;

        assign w_alloc = w_grant   && (wr_ptr_q == SrcW'(s));
        assign w_fill  = w_d_match && (w_d_idx  == SrcW'(s));
        assign w_free  = w_retire  && (rd_ptr_q == SrcW'(s));

        always_comb begin
            busy_d    = busy_q;
            done_d    = done_q;
            is_read_d = is_read_q;
            err_d     = err_q;
            data_d    = data_q;
            // A free slot is never also being retired, and a retiring slot
            // is never also being filled, so the branches do not collide.
            if (w_alloc) begin
                busy_d    = 1'b1;
                is_read_d = !we_i;
            end else if (w_free) begin
                busy_d    = 1'b0;
            end
            if (w_fill) begin
                done_d = 1'b1;
                err_d  = w_d_err;
                data_d = w_d_data;
            end else if (w_free) begin
                done_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                is_read_q <= 1'b0;
                err_q     <= 1'b0;
                data_q    <= 32'h0;
            end else begin
                busy_q    <= busy_d;
                done_q    <= done_d;
                is_read_q <= is_read_d;
                err_q     <= err_d;
                data_q    <= data_d;
            end
        end

        assign w_busy[s]      = busy_q;
        assign w_done[s]      = done_q;
        assign w_is_read[s]   = is_read_q;
        assign w_err[s]       = err_q;
        assign w_slot_data[s] = data_q;
    end

    for (genvar p = MaxOutstanding; p < NUM_SLOTS; p++) begin : g_pad
        assign w_busy[p]      = 1'b0;
        assign w_done[p]      = 1'b0;
        assign w_is_read[p]   = 1'b0;
        assign w_err[p]       = 1'b0;
        assign w_slot_data[p] = 32'h0;
    end

    // ------------------------------------------------------------------
    // Pointer, occupancy and sticky-flag next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        spurious_d = spurious_q;

        // Explicit wrap so non-power-of-two depths stay in range
        if (w_grant) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + SrcW'(1);
        end
        if (w_retire) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + SrcW'(1);
        end

        case ({w_grant, w_retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (tl_i.d_valid && !w_d_match) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
        end
    end

    // ------------------------------------------------------------------
    // A channel: purely combinational from the core request
    // ------------------------------------------------------------------
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = w_a_valid;
        if (!we_i) begin
            tl_o.a_opcode = GET;
        end else if (be_i == 4'hF) begin
            tl_o.a_opcode = PUT_FULL_DATA;
        end else begin
            tl_o.a_opcode = PUT_PARTIAL_DATA;
        end
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = TL_SZW'(2);
        tl_o.a_source  = TL_AIW'(wr_ptr_q);
        tl_o.a_address = addr_i & ~32'h3;   // word aligned
        tl_o.a_mask    = we_i ? be_i : 4'hF;
        tl_o.a_data    = wdata_i;
        tl_o.a_user    = TL_A_USER_DEFAULT;
        // Every outstanding transaction owns a slot, so D is always accepted
        tl_o.d_ready   = 1'b1;
    end

    // ------------------------------------------------------------------
    // Core-side response
    // ------------------------------------------------------------------
    assign gnt_o      = w_grant;
    assign rvalid_o   = w_retire;
    assign rdata_o    = w_retire ? w_slot_data[rd_ptr_q] : 32'h0;
    assign err_o      = w_retire && w_err[rd_ptr_q];
    assign spurious_o = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_tlul_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlul_host_bridge
// Purpose  : Self-checking bench for tlul_host_bridge. A-channel decode is
//            checked from a vector table; transaction behaviour is checked
//            each cycle against a queue-based model of in-order retirement.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlul_host_bridge;

    localparam int MAXO = 2;
    localparam int SRCW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        a_ready;
    logic        d_valid;
    logic [2:0]  d_op;
    logic [7:0]  d_src;
    logic [31:0] d_data;
    logic        d_err;

    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        spurious_o;
    tlul_pkg::tl_h2d_t tl_o;
    tlul_pkg::tl_d2h_t tl_i;

    always #5 clk = ~clk;

    always_comb begin
        tl_i          = '0;
        tl_i.d_valid  = d_valid;
        tl_i.d_opcode = d_op;
        tl_i.d_source = d_src;
        tl_i.d_data   = d_data;
        tl_i.d_error  = d_err;
        tl_i.a_ready  = a_ready;
    end

    tlul_host_bridge #(
        .MaxOutstanding (MAXO),
        .SrcW           (SRCW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .gnt_o      (gnt_o),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .be_i       (be),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .spurious_o (spurious_o),
        .tl_o       (tl_o),
        .tl_i       (tl_i)
    );

    // ------------------------------------------------------------------
    // Reference model: outstanding transactions in issue order
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  src;
        bit          rd;
        bit          done;
        logic [31:0] data;
        bit          err;
    } txn_t;

    txn_t q[$];
    int   issued;
    bit   m_spur;
    bit   last_gnt;

    int   vec_cnt;
    int   miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called in the low clock phase with inputs already driven: checks all
    // outputs against the model, crosses one rising edge, updates the model.
    task automatic tick();
        bit          ev, eg, erv;
        logic [31:0] erd;
        bit          eer;
        bit          found;
        #1;
        ev  = req && (q.size() < MAXO);
        eg  = ev && a_ready;
        erv = (q.size() > 0) && q[0].done;
        erd = erv ? q[0].data : 32'h0;
        eer = erv ? q[0].err  : 1'b0;
        chk("a_valid",  32'(tl_o.a_valid), 32'(ev));
        chk("gnt",      32'(gnt_o),        32'(eg));
        chk("rvalid",   32'(rvalid_o),     32'(erv));
        chk("rdata",    rdata_o,           erd);
        chk("err",      32'(err_o),        32'(eer));
        chk("spurious", 32'(spurious_o),   32'(m_spur));
        chk("d_ready",  32'(tl_o.d_ready), 32'd1);
        if (ev) chk("a_source", 32'(tl_o.a_source), 32'(issued % MAXO));
        @(posedge clk);
        if (d_valid && rst_n) begin
            found = 0;
            foreach (q[i]) begin
                if (!found && q[i].src == d_src && !q[i].done) begin
                    q[i].done = 1;
                    q[i].data = q[i].rd ? d_data : 32'h0;
                    q[i].err  = d_err || (q[i].rd ? (d_op != 3'd1) : (d_op != 3'd0));
                    found     = 1;
                end
            end
            if (!found) m_spur = 1;
        end
        if (erv) void'(q.pop_front());
        if (eg) begin
            q.push_back('{src: 8'(issued % MAXO), rd: !we, done: 0, data: 32'h0, err: 0});
            issued++;
        end
        last_gnt = eg;
        @(negedge clk);
    endtask

    // Answer every outstanding transaction correctly and let all retire
    task automatic drain();
        int  guard;
        bit  sent;
        guard = 0;
        req   = 0;
        while (q.size() > 0 && guard < 50) begin
            d_valid = 0;
            sent    = 0;
            foreach (q[i]) begin
                if (!sent && !q[i].done) begin
                    d_valid = 1;
                    d_src   = q[i].src;
                    d_op    = q[i].rd ? 3'd1 : 3'd0;
                    d_data  = $urandom;
                    d_err   = 0;
                    sent    = 1;
                end
            end
            tick();
            guard++;
        end
        d_valid = 0;
        if (q.size() != 0) begin
            vec_cnt++;
            miscompares++;
            $display("FAIL drain: got %0d outstanding expected 0", q.size());
        end
    endtask

    // ------------------------------------------------------------------
    // A-channel decode table
    // ------------------------------------------------------------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  exp_op;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   cand[$];
        int   k;
        logic [7:0] s0, s1;

        vecs[0] = '{we: 0, addr: 32'h1000_0006, wdata: 32'h0,         be: 4'h0, exp_op: 3'd4, exp_addr: 32'h1000_0004, exp_mask: 4'hF};
        vecs[1] = '{we: 0, addr: 32'hFFFF_FFFF, wdata: 32'h1234_5678, be: 4'h3, exp_op: 3'd4, exp_addr: 32'hFFFF_FFFC, exp_mask: 4'hF};
        vecs[2] = '{we: 1, addr: 32'h0000_0003, wdata: 32'hA5A5_5A5A, be: 4'hF, exp_op: 3'd0, exp_addr: 32'h0000_0000, exp_mask: 4'hF};
        vecs[3] = '{we: 1, addr: 32'h2000_0001, wdata: 32'h0BAD_F00D, be: 4'h3, exp_op: 3'd1, exp_addr: 32'h2000_0000, exp_mask: 4'h3};
        vecs[4] = '{we: 1, addr: 32'h3000_0008, wdata: 32'h1111_2222, be: 4'h0, exp_op: 3'd1, exp_addr: 32'h3000_0008, exp_mask: 4'h0};
        vecs[5] = '{we: 1, addr: 32'h4000_000E, wdata: 32'hFFFF_0000, be: 4'h8, exp_op: 3'd1, exp_addr: 32'h4000_000C, exp_mask: 4'h8};

        vec_cnt = 0; miscompares = 0;
        q.delete(); issued = 0; m_spur = 0; last_gnt = 0;
        rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        a_ready = 0; d_valid = 0; d_op = 0; d_src = 0; d_data = 0; d_err = 0;

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        chk("rst_gnt",      32'(gnt_o),        32'd0);
        chk("rst_rvalid",   32'(rvalid_o),     32'd0);
        chk("rst_err",      32'(err_o),        32'd0);
        chk("rst_spurious", 32'(spurious_o),   32'd0);
        chk("rst_rdata",    rdata_o,           32'd0);
        chk("rst_a_valid",  32'(tl_o.a_valid), 32'd0);
        chk("rst_d_ready",  32'(tl_o.d_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // ---------------- A-channel decode table (no grant) ----------------
        a_ready = 0;
        for (int i = 0; i < 6; i++) begin
            req = 1; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata; be = vecs[i].be;
            #1;
            chk("tbl_opcode", 32'(tl_o.a_opcode), 32'(vecs[i].exp_op));
            chk("tbl_addr",   tl_o.a_address,     vecs[i].exp_addr);
            chk("tbl_mask",   32'(tl_o.a_mask),   32'(vecs[i].exp_mask));
            chk("tbl_data",   tl_o.a_data,        vecs[i].wdata);
            chk("tbl_size",   32'(tl_o.a_size),   32'd2);
            chk("tbl_param",  32'(tl_o.a_param),  32'd0);
            tick();
        end
        req = 0;

        // ---------------- single read ----------------
        req = 1; we = 0; addr = 32'h1000_0006; a_ready = 1;
        #1;
        chk("rd_gnt",    32'(gnt_o),          32'd1);
        chk("rd_source", 32'(tl_o.a_source),  32'd0);
        tick();
        req = 0;
        d_valid = 1; d_src = 8'd0; d_op = 3'd1; d_data = 32'hDEAD_BEEF; d_err = 0;
        #1;
        chk("rd_no_early_rvalid", 32'(rvalid_o), 32'd0);
        tick();
        d_valid = 0;
        #1;
        chk("rd_rvalid", 32'(rvalid_o), 32'd1);
        chk("rd_rdata",  rdata_o,       32'hDEAD_BEEF);
        tick();
        #1;
        chk("rd_pulse_once", 32'(rvalid_o), 32'd0);

        // ---------------- write opcodes ----------------
        req = 1; we = 1; addr = 32'h0000_0100; wdata = 32'h1234_ABCD; be = 4'hF;
        #1;
        chk("wr_full_op", 32'(tl_o.a_opcode), 32'd0);
        tick();
        be = 4'h3; wdata = 32'h5555_AAAA;
        #1;
        chk("wr_part_op",   32'(tl_o.a_opcode), 32'd1);
        chk("wr_part_mask", 32'(tl_o.a_mask),   32'h3);
        tick();
        drain();

        // ---------------- full stall ----------------
        req = 1; we = 0; addr = 32'h0000_0200; a_ready = 1;
        #1; chk("stall_g0", 32'(gnt_o), 32'd1); tick();
        #1; chk("stall_g1", 32'(gnt_o), 32'd1); tick();
        #1; chk("stall_full", 32'(gnt_o), 32'd0); tick();
        tick();
        d_valid = 1; d_src = q[0].src; d_op = 3'd1; d_data = 32'h0000_00A1; d_err = 0;
        #1; chk("stall_full_d", 32'(gnt_o), 32'd0);
        tick();
        d_valid = 0;
        #1;
        chk("stall_retire",        32'(rvalid_o), 32'd1);
        chk("stall_no_same_cycle", 32'(gnt_o),    32'd0);
        tick();
        #1; chk("stall_regrant", 32'(gnt_o), 32'd1);
        tick();
        drain();

        // ---------------- out-of-order responses ----------------
        s0 = 8'(issued % MAXO);
        s1 = 8'((issued + 1) % MAXO);
        req = 1; we = 0; a_ready = 1;
        tick(); tick();
        req = 0;
        d_valid = 1; d_src = s1; d_op = 3'd1; d_data = 32'h22; d_err = 0;
        tick();
        d_valid = 0;
        #1; chk("ooo_wait", 32'(rvalid_o), 32'd0);
        tick(); tick();
        d_valid = 1; d_src = s0; d_data = 32'h11;
        tick();
        d_valid = 0;
        #1;
        chk("ooo_first_v", 32'(rvalid_o), 32'd1);
        chk("ooo_first_d", rdata_o,       32'h11);
        tick();
        #1;
        chk("ooo_second_v", 32'(rvalid_o), 32'd1);
        chk("ooo_second_d", rdata_o,       32'h22);
        tick();
        #1; chk("ooo_done", 32'(rvalid_o), 32'd0);

        // ---------------- error cases ----------------
        req = 1; we = 0; tick(); req = 0;
        d_valid = 1; d_src = q[0].src; d_op = 3'd1; d_data = 32'h77; d_err = 1;
        tick();
        d_valid = 0; d_err = 0;
        #1; chk("err_rd_derror", 32'(err_o), 32'd1);
        tick();
        req = 1; we = 1; be = 4'hF; tick(); req = 0;
        d_valid = 1; d_src = q[0].src; d_op = 3'd1; d_data = 32'h55;
        tick();
        d_valid = 0;
        #1;
        chk("err_wr_opcode", 32'(err_o), 32'd1);
        chk("err_wr_rdata",  rdata_o,    32'd0);
        tick();

        // ---------------- randomized traffic ----------------
        req = 0;
        for (int c = 0; c < 400; c++) begin
            if (!req || last_gnt) begin
                req   = ($urandom_range(0, 3) != 0);
                we    = 1'($urandom_range(0, 1));
                addr  = $urandom;
                wdata = $urandom;
                be    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            end
            a_ready = ($urandom_range(0, 3) != 0);
            d_valid = 0;
            cand.delete();
            foreach (q[i]) if (!q[i].done) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                k       = cand[$urandom_range(0, cand.size() - 1)];
                d_valid = 1;
                d_src   = q[k].src;
                d_data  = $urandom;
                d_err   = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 7) == 0) d_op = q[k].rd ? 3'd0 : 3'd1;
                else                           d_op = q[k].rd ? 3'd1 : 3'd0;
            end
            tick();
        end
        d_valid = 0; d_err = 0;
        drain();

        // ---------------- spurious response ----------------
        d_valid = 1; d_src = 8'd3; d_op = 3'd0; d_data = 32'h0;
        #1; chk("spur_before", 32'(spurious_o), 32'd0);
        tick();
        d_valid = 0;
        #1;
        chk("spur_set",    32'(spurious_o), 32'd1);
        chk("spur_no_rsp", 32'(rvalid_o),   32'd0);
        tick();

        // ---------------- reset recovery ----------------
        req = 1; we = 0; a_ready = 1; addr = 32'h0000_0300;
        tick(); tick();
        req = 0;
        #2;
        rst_n = 0;
        q.delete(); issued = 0; m_spur = 0;
        #1;
        chk("rr_gnt",      32'(gnt_o),      32'd0);
        chk("rr_rvalid",   32'(rvalid_o),   32'd0);
        chk("rr_spurious", 32'(spurious_o), 32'd0);
        chk("rr_rdata",    rdata_o,         32'd0);
        @(negedge clk);
        tick();
        rst_n = 1;
        req = 1; we = 0;
        #1; chk("rr_source0", 32'(tl_o.a_source), 32'd0);
        tick();
        req = 0;
        d_valid = 1; d_src = 8'd0; d_op = 3'd1; d_data = 32'hCAFE_0001;
        tick();
        d_valid = 0;
        #1; chk("rr_rdata_new", rdata_o, 32'hCAFE_0001);
        tick();
        d_valid = 1; d_src = 8'd1; d_op = 3'd1; d_data = 32'h0;
        tick();
        d_valid = 0;
        #1; chk("rr_late_spurious", 32'(spurious_o), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
